alu_op_sequencer: RTL



---
 rtl/alu_op_sequencer.sv | 77 +++++++
 1 files changed

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: FIFO-buffered issue stage that drives a combinational alu
// and presents registered results on a valid/ready output with error flagging.
module alu_op_sequencer #(
    parameter int W     = 4,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_x,
    input  logic [W-1:0] in_y,
    input  logic [2:0]   in_op,
    output logic [W-1:0] alu_x,
    output logic [W-1:0] alu_y,
    output logic [2:0]   alu_op,
    input  logic [W-1:0] alu_result,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_result,
    output logic         out_err,
    output logic [7:0]   done_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
    logic [W-1:0]  mem_x  [DEPTH];
    logic [W-1:0]  mem_y  [DEPTH];
    logic [2:0]    mem_op [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          busy;
    logic          push;
    logic          pop;
    logic          drain;
    always_comb begin
        busy     = count != '0;
        in_ready = count != FULL;
        push     = in_valid && in_ready;
        pop      = busy && (!out_valid || out_ready);
        drain    = out_valid && out_ready;
        alu_x    = busy ? mem_x[rd_ptr] : '0;
        alu_y    = busy ? mem_y[rd_ptr] : '0;
        alu_op   = busy ? mem_op[rd_ptr] : '0;
    end
    always_ff @(posedge clk) begin
        if (push) begin
            mem_x[wr_ptr]  <= in_x;
            mem_y[wr_ptr]  <= in_y;
            mem_op[wr_ptr] <= in_op;
        end
    end
    // op[2] set means the alu does not decode it, so its result is discarded
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            out_valid  <= 1'b0;
            out_result <= '0;
            out_err    <= 1'b0;
            done_cnt   <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
            if (pop) begin
                out_valid  <= 1'b1;
                out_result <= alu_op[2] ? '0 : alu_result;
                out_err    <= alu_op[2];
            end else if (drain) begin
                out_valid <= 1'b0;
            end
            if (drain) done_cnt <= done_cnt + 8'd1;
        end
    end
endmodule
